// File: rtl/onchip_rom_reader_pkg.sv
// Shared types and constants for the on-chip ROM stream reader.
package onchip_rom_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    // Fixed Avalon-MM sideband values: read-only initiator, all bytes, clock always enabled.
    localparam logic       AV_WRITE_TIE  = 1'b0;
    localparam logic [3:0] AV_BYTEEN_TIE = 4'hF;
    localparam logic       AV_CLKEN_TIE  = 1'b1;

    // Pointer width for a power-of-two FIFO; never below 1 bit.
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rom_reader_fifo.sv
// Return-data buffer: synchronous show-ahead FIFO, head word read straight from the storage flops.
module rom_reader_fifo
    import onchip_rom_reader_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PW   = fifo_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic [PW:0]      used_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      used_q;
    logic             do_pop;

    // A pop on an empty buffer is dropped so occupancy can never underflow.
    assign do_pop  = pop_i && (used_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (used_q == '0);
    assign used_o  = used_q;

    // Payload storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers and occupancy; push and pop together leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, do_pop})
                2'b10:   used_q <= used_q + 1'b1;
                2'b01:   used_q <= used_q - 1'b1;
                default: used_q <= used_q;
            endcase
        end
    end

    // The initiator's credit check must keep pushes off a full buffer.
    a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
        !(push_i && !do_pop && (used_q == (PW+1)'(DEPTH))));

endmodule

// File: rtl/onchip_rom_stream_reader.sv
// Avalon-MM read initiator for a fixed-latency ROM, re-emitting the words as a framed Avalon-ST stream.
module onchip_rom_stream_reader
    import onchip_rom_reader_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 13,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
);

    localparam int PW  = fifo_ptr_w(FIFO_DEPTH);
    localparam int IFW = $clog2(READ_LATENCY + 1);
    localparam logic [PW+1:0] DEPTH_L = (PW+2)'(FIFO_DEPTH);

    rd_state_e               state_q;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        issued_q, issued_d;
    logic [CNT_W-1:0]        popped_q, popped_d;
    logic [READ_LATENCY-1:0] pipe_q;
    logic [IFW-1:0]          inflight;
    logic [PW:0]             used;
    logic                    empty, credit_ok, issue, last_issue, beat, last_beat;
    logic                    busy_q, done_q;

    // Words still in the ROM pipeline, counted against the buffer space.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + IFW'(pipe_q[i]);
    end

    // Only issue when every outstanding word already has a slot reserved.
    assign credit_ok  = ({1'b0, used} + (PW+2)'(inflight)) < DEPTH_L;
    assign issue      = (state_q == READ) && (issued_q != count_q) && credit_ok;
    assign last_issue = issue && (issued_q == count_q - 1'b1);

    assign st_valid   = !empty;
    assign beat       = st_valid && st_ready;
    assign st_sop     = st_valid && (popped_q == '0);
    assign st_eop     = st_valid && (popped_q == count_q - 1'b1);
    assign last_beat  = beat && st_eop;

    assign addr_d     = issue ? addr_q + 1'b1 : addr_q;
    assign issued_d   = issued_q + CNT_W'(issue);
    assign popped_d   = popped_q + CNT_W'(beat);

    assign m_address    = addr_q;
    assign m_chipselect = issue;
    assign m_write      = AV_WRITE_TIE;
    assign m_byteenable = AV_BYTEEN_TIE;
    assign m_clken      = AV_CLKEN_TIE;
    assign busy         = busy_q;
    assign done         = done_q;

    // Issue strobe delayed by the ROM latency marks the cycle m_readdata is valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // Transfer control: address/count bookkeeping, state and registered busy/done.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            issued_q <= '0;
            popped_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q   <= start_addr;
                        count_q  <= word_count;
                        issued_q <= '0;
                        popped_q <= '0;
                        if (word_count == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= READ;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (last_issue) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (last_beat) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    rom_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (pipe_q[READ_LATENCY-1]),
        .wdata_i (m_readdata),
        .pop_i   (beat),
        .head_o  (st_data),
        .empty_o (empty),
        .used_o  (used)
    );

endmodule

// File: tb/tb_onchip_rom_stream_reader.sv
// Bench: six reader configurations (latency 1..3 x depth 4/8) share one stimulus stream; each has its
// own ROM model and transfer model, and configuration 0 (latency 1, depth 4) is also pinned by literals.
module tb_onchip_rom_stream_reader;

    localparam int NCFG = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start, tb_ready, rnd_mode;
    logic [11:0] start_addr;
    logic [12:0] word_count;

    logic [NCFG-1:0]       busy_w, done_w, cs_w, valid_w, rdy_w, sop_w, eop_w, wr_w, clken_w;
    logic [NCFG-1:0][11:0] addr_w;
    logic [NCFG-1:0][31:0] data_w;
    logic [NCFG-1:0][3:0]  be_w;

    int checks, errors, n_starts;
    int done_seen [NCFG];

    task automatic chk(input string nm, input int cfg, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d: got %0h, expected %0h", nm, cfg, got, exp);
        end
    endtask

    task automatic chk_le(input string nm, input int cfg, input int got, input int lim);
        checks++;
        if (got > lim) begin
            errors++;
            $display("FAIL %s cfg%0d: got %0d, expected <= %0d", nm, cfg, got, lim);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int RL = (g % 3) + 1;
        localparam int FD = (g < 3) ? 4 : 8;

        logic [11:0] ap [RL];
        logic [31:0] rdata;
        logic        rbit;

        onchip_rom_stream_reader #(
            .ADDR_W(12), .DATA_W(32), .CNT_W(13), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
            .word_count(word_count), .busy(busy_w[g]), .done(done_w[g]),
            .m_address(addr_w[g]), .m_chipselect(cs_w[g]), .m_write(wr_w[g]),
            .m_byteenable(be_w[g]), .m_clken(clken_w[g]), .m_readdata(rdata),
            .st_data(data_w[g]), .st_valid(valid_w[g]), .st_ready(rdy_w[g]),
            .st_sop(sop_w[g]), .st_eop(eop_w[g])
        );

        // ROM: data for the address presented RL cycles ago, mem[i] = A5000000 + i
        always @(posedge clk) begin
            ap[0] <= addr_w[g];
            for (int i = 1; i < RL; i++) ap[i] <= ap[i-1];
        end
        assign rdata = 32'hA500_0000 + {20'd0, ap[RL-1]};

        initial begin
            rbit = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                rbit = 1'($urandom_range(0, 1));
            end
        end
        assign rdy_w[g] = rnd_mode ? rbit : tb_ready;

        // Transfer model: phase 0 idle, 1 transferring, 2 done cycle
        int ph = 0, base = 0, cnt = 0, beat = 0, iss = 0;
        bit first = 0, hold = 0;
        logic [31:0] pdata = '0;

        always @(negedge clk) begin
            chk("busy", g, busy_w[g], ph == 1);
            chk("done", g, done_w[g], ph == 2);
            if (done_w[g]) done_seen[g]++;
            if (ph != 1) begin
                chk("idle_valid", g, valid_w[g], 0);
                chk("idle_cs", g, cs_w[g], 0);
                chk("idle_sop_eop", g, {sop_w[g], eop_w[g]}, 0);
            end
            if (ph == 1 && first) chk("first_cs", g, cs_w[g], 1);
            first = 0;
            if (ph == 1 && cs_w[g]) begin
                chk_le("issued_le_count", g, iss + 1, cnt);
                chk("m_address", g, addr_w[g], (base + iss) % 4096);
                iss++;
                chk_le("outstanding", g, iss - beat, FD);
            end
            if (hold) begin
                chk("hold_valid", g, valid_w[g], 1);
                chk("hold_data", g, data_w[g], pdata);
            end
            if (ph == 1 && valid_w[g] && rdy_w[g]) begin
                chk("st_data", g, data_w[g], 32'hA500_0000 + ((base + beat) % 4096));
                chk("st_sop", g, sop_w[g], beat == 0);
                chk("st_eop", g, eop_w[g], beat == cnt - 1);
                beat++;
            end
            hold  = valid_w[g] && !rdy_w[g];
            pdata = data_w[g];
            if (!reset_n) begin
                ph = 0; hold = 0; first = 0;
            end else begin
                case (ph)
                    0: if (start) begin
                        base = int'(start_addr); cnt = int'(word_count);
                        beat = 0; iss = 0; first = (cnt != 0);
                        ph = (cnt == 0) ? 2 : 1;
                    end
                    1: if (beat == cnt) ph = 2;
                    default: ph = 0;
                endcase
            end
        end
    end

    // Per-transfer log of configuration 0 for the literal expectations
    int cs_n, first_cs, last_cs, beats, first_valid, sop_beat, eop_beat, sop_n, eop_n;
    int eop_k, done_k, done_n, busy_n, max_out;
    logic busy_at_done;
    logic [11:0] addr_log [$];
    logic [31:0] data_log [$];

    task automatic do_start(input logic [11:0] a, input logic [12:0] n);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; word_count = n;
        @(posedge clk); #1;
        start = 1'b0;
        n_starts++;
    endtask

    task automatic log_run(input int maxk, input int hold_len, input int pa, input int pb);
        int stall_left;
        cs_n = 0; first_cs = -1; last_cs = -1; beats = 0; first_valid = -1;
        sop_beat = -1; eop_beat = -1; sop_n = 0; eop_n = 0; eop_k = -1; done_k = -1;
        done_n = 0; busy_n = 0; max_out = 0; busy_at_done = 1'b1; stall_left = 0;
        addr_log.delete(); data_log.delete();
        for (int k = 1; k <= maxk; k++) begin
            @(negedge clk);
            if (cs_w[0]) begin
                if (first_cs < 0) first_cs = k;
                last_cs = k; cs_n++;
                addr_log.push_back(addr_w[0]);
            end
            if (cs_n - beats > max_out) max_out = cs_n - beats;
            if (busy_w[0]) busy_n++;
            if (valid_w[0] && first_valid < 0) begin first_valid = k; stall_left = hold_len; end
            if (valid_w[0] && rdy_w[0]) begin
                data_log.push_back(data_w[0]);
                if (sop_w[0]) begin sop_n++; sop_beat = beats; end
                if (eop_w[0]) begin eop_n++; eop_beat = beats; eop_k = k; end
                beats++;
            end
            if (done_w[0]) begin
                done_n++;
                if (done_k < 0) begin done_k = k; busy_at_done = busy_w[0]; end
            end
            if (done_k > 0 && k >= done_k + 8) break;
            @(posedge clk); #1;
            start = (k + 1 == pa) || (k + 1 == pb);
            if (stall_left > 0) begin tb_ready = 1'b0; stall_left--; end
            else tb_ready = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0; tb_ready = 1'b1;
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (busy_w == '0 && done_w == '0) begin ok = 1; break; end
        end
        chk("idle_wait", 0, ok, 1);
    endtask

    initial begin
        int mism, cnt_v, seen_valid;
        reset_n = 1'b0; start = 1'b0; start_addr = '0; word_count = '0;
        tb_ready = 1'b1; rnd_mode = 1'b0; checks = 0; errors = 0; n_starts = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", 0, {busy_w[0], done_w[0], cs_w[0], valid_w[0], sop_w[0], eop_w[0]}, 6'b0);
        chk("rst_m_address", 0, addr_w[0], 12'h000);
        chk("tie_write_be_clken", 0, {wr_w[0], be_w[0], clken_w[0]}, 6'b0_1111_1);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 1: eight words from 0x010, unthrottled
        do_start(12'h010, 13'd8);
        log_run(60, 0, 0, 0);
        chk("t1_first_cs", 0, first_cs, 1);
        chk("t1_cs_count", 0, cs_n, 8);
        chk("t1_last_cs", 0, last_cs, 8);
        chk("t1_first_valid", 0, first_valid, 3);
        chk("t1_beats", 0, beats, 8);
        chk("t1_data0", 0, data_log[0], 32'hA500_0010);
        chk("t1_data7", 0, data_log[7], 32'hA500_0017);
        chk("t1_sop", 0, {sop_n, sop_beat}, {32'd1, 32'd0});
        chk("t1_eop", 0, {eop_n, eop_beat}, {32'd1, 32'd7});
        chk("t1_eop_cycle", 0, eop_k, 10);
        chk("t1_done_cycle", 0, done_k, 11);
        chk("t1_busy_at_done", 0, busy_at_done, 0);
        chk("t1_busy_cycles", 0, busy_n, 10);
        chk("t1_done_count", 0, done_n, 1);
        wait_idle(100);

        // 2: address wrap at the top of the ROM
        do_start(12'hFFE, 13'd4);
        log_run(60, 0, 0, 0);
        chk("t2_addr0", 0, addr_log[0], 12'hFFE);
        chk("t2_addr1", 0, addr_log[1], 12'hFFF);
        chk("t2_addr2", 0, addr_log[2], 12'h000);
        chk("t2_addr3", 0, addr_log[3], 12'h001);
        chk("t2_data1", 0, data_log[1], 32'hA500_0FFF);
        chk("t2_data2", 0, data_log[2], 32'hA500_0000);
        chk("t2_beats", 0, beats, 4);
        wait_idle(100);

        // 3: sixteen words with a 10-cycle stall right after the first beat
        do_start(12'h100, 13'd16);
        log_run(300, 10, 0, 0);
        mism = 0;
        foreach (data_log[i]) if (data_log[i] != 32'hA500_0100 + i) mism++;
        chk("t3_beats", 0, beats, 16);
        chk("t3_seq_mismatches", 0, mism, 0);
        chk("t3_cs_count", 0, cs_n, 16);
        chk("t3_max_outstanding", 0, max_out, 4);
        chk("t3_done_count", 0, done_n, 1);
        wait_idle(200);

        // 4: zero-length and single-word transfers
        do_start(12'h200, 13'd0);
        log_run(30, 0, 0, 0);
        chk("t4_zero_done_cycle", 0, done_k, 1);
        chk("t4_zero_cs", 0, cs_n, 0);
        chk("t4_zero_busy", 0, busy_n, 0);
        chk("t4_zero_beats", 0, beats, 0);
        wait_idle(100);
        do_start(12'h005, 13'd1);
        log_run(30, 0, 0, 0);
        chk("t4_one_beats", 0, beats, 1);
        chk("t4_one_sop_eop", 0, {sop_n, eop_n, sop_beat, eop_beat}, {32'd1, 32'd1, 32'd0, 32'd0});
        chk("t4_one_data", 0, data_log[0], 32'hA500_0005);
        chk("t4_one_cs", 0, cs_n, 1);
        wait_idle(100);

        // 5: extra start pulses while reading and during the done cycle are ignored
        do_start(12'h020, 13'd2);
        log_run(60, 0, 3, 5);
        chk("t5_done_cycle", 0, done_k, 5);
        chk("t5_done_count", 0, done_n, 1);
        chk("t5_beats", 0, beats, 2);
        wait_idle(100);

        // 6: one-cycle reset in the middle of a transfer, then a clean transfer
        do_start(12'h040, 13'd12);
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("t6_rst_outputs", 0, {busy_w[0], done_w[0], cs_w[0], valid_w[0], sop_w[0], eop_w[0]}, 6'b0);
        chk("t6_rst_addr", 0, addr_w[0], 12'h000);
        seen_valid = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid_w != '0 || done_w != '0) seen_valid++;
        end
        chk("t6_no_stale", 0, seen_valid, 0);
        do_start(12'h050, 13'd3);
        log_run(40, 0, 0, 0);
        chk("t6_beats", 0, beats, 3);
        chk("t6_data0", 0, data_log[0], 32'hA500_0050);
        chk("t6_data2", 0, data_log[2], 32'hA500_0052);
        chk("t6_done_count", 0, done_n, 1);
        wait_idle(100);

        // Sweep: random backpressure on every configuration
        @(posedge clk); #1;
        rnd_mode = 1'b1;
        for (int t = 0; t < 5; t++) begin
            case (t)
                0: cnt_v = 20;
                1: cnt_v = 9;
                2: cnt_v = 1;
                3: cnt_v = 0;
                default: cnt_v = 33;
            endcase
            do_start(12'h7F8 + 12'(t * 12'h3F0), 13'(cnt_v));
            wait_idle(3000);
        end

        // One aborted transfer never completes
        for (int g = 0; g < NCFG; g++) chk("done_total", g, done_seen[g], n_starts - 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cfg0: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
